fmul_arbiter: RTL

Shares one pipelined `fmul` instance between two requesters (integer-core FPU issue port 0, vector/aux port 1). Arbitration is round-robin with valid/ready handshakes. Each operation is tagged with its requester ID through the multiplier pipeline, and results are steered into per-requester result FIFOs. Credit tracking guarantees that a result never arrives at a full FIFO, so the multiplier pipeline never stalls.

---
 rtl/fpu_pkg.sv | 18 +
 rtl/fmul.sv | 80 ++++++++
 rtl/fmul_res_fifo.sv | 57 +++++
 rtl/fmul_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: requester ID width, default multiplier latency,
// the tag carried alongside each operation and the arbiter's grant-history state.
package fpu_pkg;

    localparam int REQ_ID_W = 1;
    localparam int FMUL_LAT = 3;

    typedef struct packed {
        logic                valid;
        logic [REQ_ID_W-1:0] id;
    } fmul_tag_t;

    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fmul.sv
// Pipelined IEEE-754 single multiplier, round-to-nearest-even. Denormal inputs
// and results flush to zero; Inf/NaN inputs give Inf. ovf leads y by one cycle.
module fmul #(
    parameter int NSTAGE = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf
);

    logic        sgn;
    logic [7:0]  e1;
    logic [7:0]  e2;
    logic [47:0] prod;
    logic        norm;
    logic        guard;
    logic        sticky;
    logic        rnd;
    logic [22:0] frac;
    logic [23:0] frac_r;
    logic [9:0]  e_sum;
    logic [31:0] y_c;
    logic        ovf_c;

    always_comb begin
        sgn  = x1[31] ^ x2[31];
        e1   = x1[30:23];
        e2   = x2[30:23];
        prod = 48'({1'b1, x1[22:0]}) * 48'({1'b1, x2[22:0]});
        norm = prod[47];
        if (norm) begin
            frac   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
        end else begin
            frac   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        rnd    = guard & (sticky | frac[0]);
        frac_r = {1'b0, frac} + {23'b0, rnd};
        // biased exponent sum still carries one extra bias of 127
        e_sum  = {2'b0, e1} + {2'b0, e2} + {9'b0, norm} + {9'b0, frac_r[23]};
        ovf_c  = 1'b0;
        if (e1 == 8'hFF || e2 == 8'hFF) begin
            y_c = {sgn, 8'hFF, 23'b0};
        end else if (e1 == 8'h00 || e2 == 8'h00) begin
            y_c = {sgn, 31'b0};
        end else if (e_sum >= 10'd382) begin
            y_c   = {sgn, 8'hFF, 23'b0};
            ovf_c = 1'b1;
        end else if (e_sum <= 10'd127) begin
            y_c = {sgn, 31'b0};
        end else begin
            y_c = {sgn, 8'(e_sum - 10'd127), frac_r[22:0]};
        end
    end

    logic [31:0] y_pipe   [NSTAGE];
    logic        ovf_pipe [NSTAGE-1];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NSTAGE; i++)     y_pipe[i]   <= '0;
            for (int i = 0; i < NSTAGE - 1; i++) ovf_pipe[i] <= 1'b0;
        end else begin
            y_pipe[0]   <= y_c;
            ovf_pipe[0] <= ovf_c;
            for (int i = 1; i < NSTAGE; i++)     y_pipe[i]   <= y_pipe[i-1];
            for (int i = 1; i < NSTAGE - 1; i++) ovf_pipe[i] <= ovf_pipe[i-1];
        end
    end

    assign y   = y_pipe[NSTAGE-1];
    assign ovf = ovf_pipe[NSTAGE-2];

endmodule

// File: rtl/fmul_res_fifo.sv
// Synchronous result FIFO with a registered head entry and exposed occupancy;
// pointers wrap modulo DEPTH (power of two).
module fmul_res_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nxt;
    logic             pop_ok;

    assign pop_ok = pop & (count != '0);
    assign rd_nxt = rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_nxt;
            case ({push, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            // head always mirrors the entry at rd_ptr, or zero when empty
            if (pop_ok) begin
                if (count > CW'(1)) head <= mem[rd_nxt];
                else if (push)      head <= wdata;
                else                head <= '0;
            end else if (push && count == '0) begin
                head <= wdata;
            end
        end
    end

endmodule

// File: rtl/fmul_arbiter.sv
// Round-robin sharing of one pipelined fmul between two requesters, with credit-
// guarded per-requester result FIFOs. Optional macro: FMUL_ARB_OVF_EN (overflow flag path).
//
// state | meaning
// LAST0 | requester 0 won the most recent grant
// LAST1 | requester 1 won the most recent grant (reset value, so 0 wins first contention)
module fmul_arbiter
    import fpu_pkg::*;
#(
    parameter int NSTAGE     = FMUL_LAT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_x1,
    input  logic [31:0] req0_x2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_x1,
    input  logic [31:0] req1_x2,
    output logic        res0_valid,
    input  logic        res0_ready,
    output logic [31:0] res0_y,
    output logic        res0_ovf,
    output logic        res1_valid,
    input  logic        res1_ready,
    output logic [31:0] res1_y,
    output logic        res1_ovf
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int INF_W = $clog2(NSTAGE + 1);
    localparam int SUM_W = CNT_W + INF_W;
`ifdef FMUL_ARB_OVF_EN
    localparam int DW = 33;
`else
    localparam int DW = 32;
`endif

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic             cand0;
    logic             cand1;
    logic             gnt0;
    logic             gnt1;
    logic [CNT_W-1:0] count0;
    logic [CNT_W-1:0] count1;
    logic [INF_W-1:0] inflight0;
    logic [INF_W-1:0] inflight1;
    logic [31:0]      fmul_x1;
    logic [31:0]      fmul_x2;
    logic [31:0]      fmul_y;
    logic [DW-1:0]    fifo_wdata;
    logic [DW-1:0]    head0;
    logic [DW-1:0]    head1;
    fmul_tag_t        tag_pipe [NSTAGE];
    fmul_tag_t        tag_in;
    fmul_tag_t        tag_out;
    logic             ret0;
    logic             ret1;

    // credits: ops in the pipe plus entries already queued must fit the FIFO
    assign cand0 = req0_valid & ((SUM_W'(inflight0) + SUM_W'(count0)) < SUM_W'(FIFO_DEPTH));
    assign cand1 = req1_valid & ((SUM_W'(inflight1) + SUM_W'(count1)) < SUM_W'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) state_q <= LAST1;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (gnt0)      state_d = LAST0;
        else if (gnt1) state_d = LAST1;
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            gnt0 = cand0 & (~cand1 | (state_q == LAST1));
            gnt1 = cand1 & (~cand0 | (state_q == LAST0));
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        fmul_x1 = '0;
        fmul_x2 = '0;
        if (gnt0) begin
            fmul_x1 = req0_x1;
            fmul_x2 = req0_x2;
        end else if (gnt1) begin
            fmul_x1 = req1_x1;
            fmul_x2 = req1_x2;
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = gnt0 | gnt1;
        tag_in.id    = REQ_ID_W'(gnt1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSTAGE; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < NSTAGE; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign tag_out = tag_pipe[NSTAGE-1];
    assign ret0    = tag_out.valid & (tag_out.id == REQ_ID_W'(0));
    assign ret1    = tag_out.valid & (tag_out.id == REQ_ID_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight0 <= '0;
            inflight1 <= '0;
        end else begin
            case ({gnt0, ret0})
                2'b10:   inflight0 <= inflight0 + INF_W'(1);
                2'b01:   inflight0 <= inflight0 - INF_W'(1);
                default: ;
            endcase
            case ({gnt1, ret1})
                2'b10:   inflight1 <= inflight1 + INF_W'(1);
                2'b01:   inflight1 <= inflight1 - INF_W'(1);
                default: ;
            endcase
        end
    end

`ifdef FMUL_ARB_OVF_EN
    logic fmul_ovf;
    logic ovf_q;

    // fmul raises ovf a cycle before y; hold it so it lines up with the tag
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= fmul_ovf;
    end

    assign fifo_wdata = {ovf_q, fmul_y};
    assign res0_ovf   = head0[32];
    assign res1_ovf   = head1[32];
`else
    assign fifo_wdata = fmul_y;
    assign res0_ovf   = 1'b0;
    assign res1_ovf   = 1'b0;
`endif

    fmul #(
        .NSTAGE(NSTAGE)
    ) u_fmul (
        .clk (clk),
        .rstn(~rst),
        .x1  (fmul_x1),
        .x2  (fmul_x2),
        .y   (fmul_y),
`ifdef FMUL_ARB_OVF_EN
        .ovf (fmul_ovf)
`else
        .ovf ()
`endif
    );

    fmul_res_fifo #(
        .WIDTH(DW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo0 (
        .clk  (clk),
        .rst  (rst),
        .push (ret0),
        .wdata(fifo_wdata),
        .pop  (res0_ready),
        .head (head0),
        .count(count0)
    );

    fmul_res_fifo #(
        .WIDTH(DW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo1 (
        .clk  (clk),
        .rst  (rst),
        .push (ret1),
        .wdata(fifo_wdata),
        .pop  (res1_ready),
        .head (head1),
        .count(count1)
    );

    assign res0_valid = (count0 != '0);
    assign res1_valid = (count1 != '0);
    assign res0_y     = head0[31:0];
    assign res1_y     = head1[31:0];

endmodule
